// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters, with a registered valid/ready output stage.
// Optional MUX_ARB_LOCK_EN adds req_lock[3:0]: a locked, still-valid last winner keeps the grant.
module mux_rr_arbiter #(
    parameter int unsigned DW   = 8,
    parameter int unsigned NREQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [1:0]         sel,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    input  logic               out_ready
`ifdef MUX_ARB_LOCK_EN
    ,
    input  logic [NREQ-1:0]    req_lock
`endif
);

    localparam int unsigned SW = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_last_grant;
    logic [SW-1:0]   r_sel;
    logic [DW-1:0]   r_out_data;

    logic [SW-1:0]   w_scan_idx;
    logic [SW-1:0]   w_grant;
    logic            w_win;
    logic            w_can_load;
    logic            w_accept;
    logic [DW-1:0]   w_word;

`ifdef MUX_ARB_LOCK_EN
    // Lock only applies once last_grant names a real winner, not the reset value.
    logic            r_lg_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lg_valid <= 1'b0;
        end else if (w_accept) begin
            r_lg_valid <= 1'b1;
        end
    end
`endif

    // Rotating priority scan starting one past the last winner.
    always_comb begin
        w_win      = 1'b0;
        w_grant    = '0;
        w_scan_idx = '0;
        for (int k = 1; k <= 4; k++) begin
            w_scan_idx = r_last_grant + SW'(k);
            if (!w_win && req_valid[w_scan_idx]) begin
                w_win   = 1'b1;
                w_grant = w_scan_idx;
            end
        end
`ifdef MUX_ARB_LOCK_EN
        if (r_lg_valid && req_lock[r_last_grant] && req_valid[r_last_grant]) begin
            w_win   = 1'b1;
            w_grant = r_last_grant;
        end
`endif
    end

    always_comb begin
        w_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_grant == SW'(i)) begin
                w_word = req_data[i*DW +: DW];
            end
        end
    end

    assign w_can_load = (r_state == ST_IDLE) || out_ready;
    assign w_accept   = w_win && w_can_load;
    assign req_ready  = w_accept ? (NREQ'(1) << w_grant) : '0;

    // Output stage occupancy: a drain and an accept in one cycle stays FULL.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end else if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= SW'(3);
            r_sel        <= '0;
            r_out_data   <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
            r_sel        <= w_grant;
            r_out_data   <= w_word;
        end
    end

    assign sel       = r_sel;
    assign out_data  = r_out_data;
    assign out_valid = (r_state == ST_FULL);

endmodule
